// File: rtl/grid_translator.sv
// Column-scanning cell-code translator: turns a ROWS x COLS grid of CODE_W-bit codes into a one-bit match map.
// The optional popcount output is enabled with GRID_TRANSLATOR_COUNT_EN.
module grid_translator #(
  parameter int ROWS   = 10,
  parameter int COLS   = 10,
  parameter int CODE_W = 2,
  parameter int LANES  = 1
) (
  input  logic                             clk_in,
  input  logic                             reset_n_in,
  input  logic                             start_in,
  input  logic [ROWS*COLS*CODE_W-1:0]      grid_in,
  input  logic [CODE_W-1:0]                match_code_in,
  input  logic                             mode_in,
  output logic [ROWS*COLS-1:0]             grid_out,
  output logic                             busy_out,
  output logic                             done_out,
`ifdef GRID_TRANSLATOR_COUNT_EN
  output logic [$clog2(ROWS*COLS+1)-1:0]   count_out,
`endif
  output logic [1:0]                       state_out
);

  localparam int CELLS = ROWS * COLS;
  localparam int COL_W = $clog2(COLS + 1);
  localparam int CNT_W = $clog2(CELLS + 1);

  if ((COLS % LANES) != 0) begin : g_lanes_check
    $error("grid_translator: COLS must be a multiple of LANES");
  end

  // Handshake: start_in is a level request sampled only in IDLE; while busy_out
  // is high any start_in is dropped, never queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state;
  logic [COL_W-1:0]           col;
  logic [CELLS*CODE_W-1:0]    grid_q;
  logic [CODE_W-1:0]          match_q;
  logic                       mode_q;
  logic [CELLS-1:0]           work_map;
  logic [CELLS-1:0]           hit_all;
  logic [CELLS-1:0]           work_next;
  logic [CNT_W-1:0]           scan_ones;
`ifdef GRID_TRANSLATOR_COUNT_EN
  logic [CNT_W-1:0]           acc;
`endif

  assign state_out = state;

  // Per-cell result from the captured snapshot; NE mode is simply the inverted compare.
  always_comb begin
    hit_all = '0;
    for (int i = 0; i < CELLS; i++) begin
      hit_all[i] = (grid_q[i*CODE_W +: CODE_W] == match_q) ^ mode_q;
    end
  end

  // Only the LANES columns in the current window are written into the working map.
  always_comb begin
    work_next = work_map;
    scan_ones = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((c >= int'(col)) && (c < int'(col) + LANES)) begin
          work_next[r*COLS+c] = hit_all[r*COLS+c];
          scan_ones = scan_ones + CNT_W'(hit_all[r*COLS+c]);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state    <= IDLE;
      col      <= '0;
      grid_q   <= '0;
      match_q  <= '0;
      mode_q   <= 1'b0;
      work_map <= '0;
      grid_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
`ifdef GRID_TRANSLATOR_COUNT_EN
      acc       <= '0;
      count_out <= '0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            grid_q   <= grid_in;
            match_q  <= match_code_in;
            mode_q   <= mode_in;
            work_map <= '0;
            col      <= '0;
            busy_out <= 1'b1;
            state    <= SCAN;
`ifdef GRID_TRANSLATOR_COUNT_EN
            acc      <= '0;
`endif
          end
        end
        SCAN: begin
          work_map <= work_next;
          col      <= col + COL_W'(LANES);
`ifdef GRID_TRANSLATOR_COUNT_EN
          acc      <= acc + scan_ones;
`endif
          // Exit on the edge that scans the last window, so col tops out at COLS.
          if (col == COL_W'(COLS - LANES)) begin
            state <= DONE;
          end
        end
        DONE: begin
          grid_out <= work_map;
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
`ifdef GRID_TRANSLATOR_COUNT_EN
          count_out <= acc;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef GRID_TRANSLATOR_COUNT_EN
  logic unused_ones;
  assign unused_ones = ^scan_ones;
`endif

endmodule

// File: tb/tb_grid_translator.sv
// Directed bench for grid_translator: a default 10x10 instance driven from a vector table,
// plus a 2x10, 3-bit, 5-lane instance and hand-written multi-cycle sequences.
module tb_grid_translator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default-size instance
  logic [199:0] b_grid;
  logic [1:0]   b_match;
  logic         b_mode;
  logic         b_start;
  logic [99:0]  b_map;
  logic         b_busy;
  logic         b_done;
  logic [1:0]   b_state;
  logic [6:0]   b_count;

  // small wide-lane instance
  logic [59:0]  s_grid;
  logic [2:0]   s_match;
  logic         s_mode;
  logic         s_start;
  logic [19:0]  s_map;
  logic         s_busy;
  logic         s_done;
  logic [1:0]   s_state;
  logic [4:0]   s_count;

  grid_translator u_big (
    .clk_in        (clk),
    .reset_n_in    (rst_n),
    .start_in      (b_start),
    .grid_in       (b_grid),
    .match_code_in (b_match),
    .mode_in       (b_mode),
    .grid_out      (b_map),
    .busy_out      (b_busy),
    .done_out      (b_done),
`ifdef GRID_TRANSLATOR_COUNT_EN
    .count_out     (b_count),
`endif
    .state_out     (b_state)
  );

  grid_translator #(.ROWS(2), .COLS(10), .CODE_W(3), .LANES(5)) u_small (
    .clk_in        (clk),
    .reset_n_in    (rst_n),
    .start_in      (s_start),
    .grid_in       (s_grid),
    .match_code_in (s_match),
    .mode_in       (s_mode),
    .grid_out      (s_map),
    .busy_out      (s_busy),
    .done_out      (s_done),
`ifdef GRID_TRANSLATOR_COUNT_EN
    .count_out     (s_count),
`endif
    .state_out     (s_state)
  );

`ifndef GRID_TRANSLATOR_COUNT_EN
  assign b_count = '0;
  assign s_count = '0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [199:0] grid;
    logic [1:0]   match;
    logic         mode;
    logic [99:0]  exp_map;
    int           exp_cnt;
  } vec_t;

  vec_t  vecs[5];
  string names[5];

  logic [199:0] g_tmp;
  logic [99:0]  e_tmp;
  logic [9:0]   row_pat;
  int           lat;
  int           extra;
  int           gap;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one job on the default instance; returns cycles from capture edge to done_out visibility.
  task automatic run_big(input logic [199:0] g, input logic [1:0] m, input logic md, output int l);
    @(negedge clk);
    b_grid = g; b_match = m; b_mode = md; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    l = 0;
    while (!b_done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_small(input logic [59:0] g, input logic [2:0] m, input logic md, output int l);
    @(negedge clk);
    s_grid = g; s_match = m; s_mode = md; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    l = 0;
    while (!s_done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    // vector table, expected maps written out by hand
    vecs[0] = '{grid: {100{2'b01}}, match: 2'b01, mode: 1'b0, exp_map: {100{1'b1}}, exp_cnt: 100};
    names[0] = "all_eq";

    g_tmp = '0; g_tmp[1:0] = 2'b01; g_tmp[199:198] = 2'b01;
    vecs[1] = '{grid: g_tmp, match: 2'b01, mode: 1'b1, exp_map: {1'b0, {98{1'b1}}, 1'b0}, exp_cnt: 98};
    names[1] = "corners_ne";

    vecs[2] = '{grid: '0, match: 2'b00, mode: 1'b1, exp_map: '0, exp_cnt: 0};
    names[2] = "all_ne_zero";

    // row r holds code r%4; match 2 hits rows 2 and 6
    g_tmp = '0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) g_tmp[(r*10+c)*2 +: 2] = 2'(r % 4);
    e_tmp = '0; e_tmp[29:20] = '1; e_tmp[69:60] = '1;
    vecs[3] = '{grid: g_tmp, match: 2'b10, mode: 1'b0, exp_map: e_tmp, exp_cnt: 20};
    names[3] = "rows_eq";

    // column c holds code c%4; match 3 hits columns 3 and 7 in every row
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) g_tmp[(r*10+c)*2 +: 2] = 2'(c % 4);
    row_pat = 10'b0010001000;
    vecs[4] = '{grid: g_tmp, match: 2'b11, mode: 1'b0, exp_map: {10{row_pat}}, exp_cnt: 20};
    names[4] = "cols_eq";

    rst_n = 1'b0;
    b_start = 1'b0; b_grid = '0; b_match = '0; b_mode = 1'b0;
    s_start = 1'b0; s_grid = '0; s_match = '0; s_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_map",   256'(b_map),   256'(0));
    check("reset_busy",  256'(b_busy),  256'(0));
    check("reset_done",  256'(b_done),  256'(0));
    check("reset_state", 256'(b_state), 256'(0));
`ifdef GRID_TRANSLATOR_COUNT_EN
    check("reset_count", 256'(b_count), 256'(0));
`endif
    check("reset_small_map", 256'(s_map), 256'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_big(vecs[i].grid, vecs[i].match, vecs[i].mode, lat);
      check({names[i], "_latency"}, 256'(lat), 256'(11));
      check({names[i], "_map"}, 256'(b_map), 256'(vecs[i].exp_map));
`ifdef GRID_TRANSLATOR_COUNT_EN
      check({names[i], "_count"}, 256'(b_count), 256'(vecs[i].exp_cnt));
`endif
      @(negedge clk);
      check({names[i], "_done_width"}, 256'(b_done), 256'(0));
      check({names[i], "_busy_after"}, 256'(b_busy), 256'(0));
    end

    // start pulsed 3 cycles into SCAN with a different grid is ignored
    @(negedge clk);
    b_grid = vecs[0].grid; b_match = 2'b01; b_mode = 1'b0; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("ignored_busy", 256'(b_busy), 256'(1));
    repeat (3) @(negedge clk);
    b_grid = '0; b_match = 2'b00; b_mode = 1'b1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    lat = 4;
    while (!b_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignored_latency", 256'(lat), 256'(11));
    check("ignored_map", 256'(b_map), 256'({100{1'b1}}));
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (b_done) extra++;
    end
    check("ignored_no_second_done", 256'(extra), 256'(0));
    run_big('0, 2'b00, 1'b1, lat);
    check("after_ignored_latency", 256'(lat), 256'(11));
    check("after_ignored_map", 256'(b_map), 256'(0));

    // reset mid-scan aborts with no done pulse
    run_big(vecs[0].grid, 2'b01, 1'b0, lat);
    check("pre_reset_map", 256'(b_map), 256'({100{1'b1}}));
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_map",  256'(b_map),  256'(0));
    check("midreset_busy", 256'(b_busy), 256'(0));
    check("midreset_state", 256'(b_state), 256'(0));
`ifdef GRID_TRANSLATOR_COUNT_EN
    check("midreset_count", 256'(b_count), 256'(0));
`endif
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (b_done) extra++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (b_done) extra++;
    end
    check("midreset_no_done", 256'(extra), 256'(0));
    run_big(vecs[1].grid, vecs[1].match, vecs[1].mode, lat);
    check("restart_latency", 256'(lat), 256'(11));
    check("restart_map", 256'(b_map), 256'(vecs[1].exp_map));

    // inputs scrambled every cycle after capture do not affect the job
    @(negedge clk);
    b_grid = vecs[3].grid; b_match = vecs[3].match; b_mode = vecs[3].mode; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    lat = 0;
    while (!b_done && lat < 40) begin
      for (int w = 0; w < 7; w++) g_tmp[w*32 +: 32] = $urandom;
      b_grid = g_tmp;
      b_match = 2'($urandom_range(0, 3));
      b_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    check("snapshot_latency", 256'(lat), 256'(11));
    check("snapshot_map", 256'(b_map), 256'(vecs[3].exp_map));
`ifdef GRID_TRANSLATOR_COUNT_EN
    check("snapshot_count", 256'(b_count), 256'(vecs[3].exp_cnt));
`endif

    // start held high relaunches every K+2 cycles
    @(negedge clk);
    b_grid = vecs[4].grid; b_match = vecs[4].match; b_mode = vecs[4].mode; b_start = 1'b1;
    lat = 0;
    while (!b_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    gap = 0;
    @(negedge clk);
    gap++;
    while (!b_done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    b_start = 1'b0;
    check("held_start_period", 256'(gap), 256'(12));
    check("held_start_map", 256'(b_map), 256'(vecs[4].exp_map));
    repeat (3) @(negedge clk);
    check("held_start_idle", 256'(b_busy), 256'(0));

    // 2x10, 3-bit codes, 5 lanes: K=2
    g_tmp = '0;
    g_tmp[53:51] = 3'b101;
    run_small(g_tmp[59:0], 3'd5, 1'b0, lat);
    check("small_eq_latency", 256'(lat), 256'(3));
    check("small_eq_map", 256'(s_map), 256'(20'h20000));
`ifdef GRID_TRANSLATOR_COUNT_EN
    check("small_eq_count", 256'(s_count), 256'(1));
`endif
    run_small(g_tmp[59:0], 3'd5, 1'b1, lat);
    check("small_ne_latency", 256'(lat), 256'(3));
    check("small_ne_map", 256'(s_map), 256'(20'hDFFFF));
`ifdef GRID_TRANSLATOR_COUNT_EN
    check("small_ne_count", 256'(s_count), 256'(19));
`endif
    @(negedge clk);
    check("small_done_width", 256'(s_done), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
